lu_serial_sequencer: RTL and testbench

Upstream and downstream partner of the 1-bit logic unit (NOR/OR/XOR/XNOR, 2-bit select). It accepts WIDTH-bit operand words and an opcode through a valid/ready handshake, then drives the combinational 1-bit logic unit one bit per cycle, LSB first. It captures each returned bit, assembles the result word and presents it on a valid/ready output port. This gives the team word-wide logic operations from the existing bit-level unit.

---
 rtl/lu_pkg.sv | 16 +
 rtl/lu_serial_sequencer.sv | 92 +++++++++
 tb/tb_lu_serial_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared opcode and state encodings for the word-serial logic unit sequencer.
// Imported by the sequencer and anything that talks to the 1-bit logic unit.
package lu_pkg;

  localparam logic [1:0] LU_NOR  = 2'b00;
  localparam logic [1:0] LU_OR   = 2'b01;
  localparam logic [1:0] LU_XOR  = 2'b10;
  localparam logic [1:0] LU_XNOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } lu_state_t;

endpackage

// File: rtl/lu_serial_sequencer.sv
// Feeds the external 1-bit logic unit one operand bit per cycle, LSB first,
// and assembles the returned bits into a word behind a valid/ready port.
module lu_serial_sequencer
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_select,
  output logic             lu_a,
  output logic             lu_b,
  output logic [1:0]       lu_select,
  input  logic             lu_s_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             busy
);

  lu_state_t        state_q;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] res_q;

  logic run;
  logic done;
  logic last;
  logic take;

  assign run  = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign last = (idx_q == CNT_W'(WIDTH - 1));

  assign in_ready = !rst &&
                    ((state_q == ST_IDLE) || (done && out_ready));
  assign take     = in_valid && in_ready;

  // Bit-level port is quiet outside RUN so the unit never sees stale data.
  assign lu_a      = run ? a_q[idx_q] : 1'b0;
  assign lu_b      = run ? b_q[idx_q] : 1'b0;
  assign lu_select = run ? sel_q : 2'b00;

  assign busy      = run;
  assign out_valid = done;
  assign out_data  = done ? res_q : '0;
  assign out_zero  = done && (res_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 2'b00;
      res_q   <= '0;
    end else if (take) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
      a_q     <= in_a;
      b_q     <= in_b;
      sel_q   <= in_select;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          res_q[idx_q] <= lu_s_out;
          if (last) begin
            state_q <= ST_DONE;
            idx_q   <= '0;
          end else begin
            idx_q   <= idx_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        ST_IDLE: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Bench for lu_serial_sequencer with a behavioural 1-bit logic unit attached
// and a word-level reference model for the assembled results.
module tb_lu_serial_sequencer;
  import lu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_select;
  logic         lu_a;
  logic         lu_b;
  logic [1:0]   lu_select;
  logic         lu_s_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;
  logic         busy;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  lu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_select(in_select),
    .lu_a(lu_a), .lu_b(lu_b), .lu_select(lu_select),
    .lu_s_out(lu_s_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .busy(busy)
  );

  // The existing 1-bit logic unit.
  always_comb begin
    case (lu_select)
      2'b00:   lu_s_out = ~(lu_a | lu_b);
      2'b01:   lu_s_out = lu_a | lu_b;
      2'b10:   lu_s_out = lu_a ^ lu_b;
      default: lu_s_out = ~(lu_a ^ lu_b);
    endcase
  end

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [1:0] s);
    case (s)
      LU_NOR:  return ~(a | b);
      LU_OR:   return a | b;
      LU_XOR:  return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_lu_a"}, lu_a, 0);
    chk({tag, "_lu_b"}, lu_b, 0);
    chk({tag, "_lu_sel"}, lu_select, 0);
  endtask

  // Presents a word (from IDLE or DONE), walks RUN, leaves the block in DONE.
  task automatic do_word(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] s, input bit scr,
                         output logic [W-1:0] res);
    logic [W-1:0] exp;
    in_a = a; in_b = b; in_select = s;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("in_ready_acc", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      chk("run_busy", busy, 1);
      chk("run_ovalid", out_valid, 0);
      chk("run_lu_a", lu_a, a[k]);
      chk("run_lu_b", lu_b, b[k]);
      chk("run_lu_sel", lu_select, s);
      if (scr) begin
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_select = 2'($urandom);
        in_valid = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    exp = ref_op(a, b, s);
    chk("done_ovalid", out_valid, 1);
    chk("done_busy", busy, 0);
    chk("done_data", out_data, exp);
    chk("done_zero", out_zero, (exp == '0));
    chk_quiet("done");
    in_valid = 1'b0;
    out_ready = 1'b0;
    res = exp;
  endtask

  task automatic consume();
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("cons_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("idle_ovalid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_data", out_data, 0);
    chk_quiet("idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r;
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_select = 2'b00;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_busy", busy, 0);
    chk_quiet("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Basic XOR and latency.
    do_word(8'hA5, 8'h0F, LU_XOR, 0, r);
    chk("t1_res", r, 8'hAA);
    consume();

    // Back-to-back words with no IDLE gap.
    do_word(8'hA5, 8'h0F, LU_NOR, 0, r);
    chk("t2_nor", r, 8'h50);
    do_word(8'hA5, 8'h0F, LU_OR, 0, r);
    chk("t2_or", r, 8'hAF);
    do_word(8'hA5, 8'h0F, LU_XNOR, 0, r);
    chk("t2_xnor", r, 8'h55);

    // Zero result, consumed back-to-back into the next word.
    do_word(8'hFF, 8'h00, LU_NOR, 0, r);
    chk("t3_res", r, 8'h00);
    chk("t3_zero", out_zero, 1);

    // Backpressure in DONE.
    held = out_data;
    in_valid = 1'b1; in_a = 8'h12; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_ovalid", out_valid, 1);
      chk("bp_data", out_data, held);
      chk("bp_zero", out_zero, 1);
    end
    consume();
    chk("bp_one_shot", out_valid, 0);

    // Reset in the 4th RUN cycle.
    in_a = 8'h77; in_b = 8'h11; in_select = LU_OR;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy0", busy, 0);
    chk("abort_ovalid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_in_ready", in_ready, 0);
    chk_quiet("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", in_ready, 1);
    do_word(8'h3C, 8'hFF, LU_XOR, 0, r);
    chk("t5_res", r, 8'hC3);
    consume();

    // Randomized words with input churn during RUN.
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   s;
      a = W'($urandom);
      b = W'($urandom);
      s = 2'($urandom);
      do_word(a, b, s, 1, r);
      if ($urandom_range(0, 1) == 1) consume();
    end
    consume();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
